// File: rtl/alu_cmd_sequencer_pkg.sv
// alu_pkg: shared types and widths for the ALU command sequencer.
//   DATA_W / OPC_W : ALU operand and opcode widths
//   alu_cmd_t      : one queued ALU command (operands, carry-in, opcode and,
//                    when ALU_SEQ_CHAIN_EN is defined, the chain bit)
//   seq_state_t    : issue/capture FSM states
// Optional feature macro: ALU_SEQ_CHAIN_EN
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int OPC_W  = 3;

  typedef struct packed {
`ifdef ALU_SEQ_CHAIN_EN
    logic              chain;
`endif
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
    logic [OPC_W-1:0]  opc;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: bundles the command handshake, the ALU drive/return
// signals and the result handshake of the ALU command sequencer.
//   slave  : sequencer view (accepts commands, drives ALU, offers results)
//   master : environment view (issues commands, models ALU, consumes results)
interface alu_cmd_sequencer_if;
  import alu_pkg::*;

  // command handshake
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              cmd_cin;
  logic [OPC_W-1:0]  cmd_opc;
  logic              cmd_chain;
  // ALU drive and return
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic              alu_cin;
  logic [OPC_W-1:0]  alu_opc;
  logic [DATA_W-1:0] alu_w;
  logic              alu_zero;
  logic              alu_neg;
  // result handshake
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_w;
  logic              res_zero;
  logic              res_neg;
  // status
  logic              busy;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_opc, cmd_chain,
    input  alu_w, alu_zero, alu_neg, res_ready,
    output cmd_ready, alu_a, alu_b, alu_cin, alu_opc,
    output res_valid, res_w, res_zero, res_neg, busy
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_opc, cmd_chain,
    output alu_w, alu_zero, alu_neg, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_cin, alu_opc,
    input  res_valid, res_w, res_zero, res_neg, busy
  );

endinterface

// File: rtl/alu_cmd_sequencer_fifo.sv
// alu_cmd_fifo: synchronous FIFO of ALU commands with a combinational head.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   push/wdata : write when push && !full
//   pop/rdata  : rdata is the current head; advance when pop && !empty
//   full/empty : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter; wptr - rptr is the occupancy.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = alu_cmd_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T             mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage carries no reset: an entry is only ever read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands, issues them one at a time on
// registered ALU inputs, waits SETTLE cycles, then captures the ALU result
// and flags into a valid/ready result register.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset; discards queued/in-flight work
//   bus    : alu_cmd_sequencer_if.slave (cmd_*, alu_*, res_*, busy)
// Parameters: DEPTH (FIFO entries, power of 2, >=2), SETTLE (hold cycles, >=1)
// Optional feature macro: ALU_SEQ_CHAIN_EN -- a command with cmd_chain=1
// takes operand A from the most recently captured result.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_cmd_sequencer_if.slave    bus
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  alu_cmd_t          wr_cmd;
  alu_cmd_t          head;
  logic              full;
  logic              empty;
  logic              push;

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic              pop;
  logic              capture;
  logic              release_res;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt;

  logic [DATA_W-1:0] a_sel;

  logic [DATA_W-1:0] alu_a_p0;
  logic [DATA_W-1:0] alu_b_p0;
  logic              alu_cin_p0;
  logic [OPC_W-1:0]  alu_opc_p0;

  logic [DATA_W-1:0] res_w_p1;
  logic              res_zero_p1;
  logic              res_neg_p1;
  logic              vld_p1;

  always_comb begin
    wr_cmd       = '0;
    wr_cmd.a     = bus.cmd_a;
    wr_cmd.b     = bus.cmd_b;
    wr_cmd.cin   = bus.cmd_cin;
    wr_cmd.opc   = bus.cmd_opc;
`ifdef ALU_SEQ_CHAIN_EN
    wr_cmd.chain = bus.cmd_chain;
`endif
  end

  // Gating with rst_n keeps the command port closed for the whole reset pulse.
  assign bus.cmd_ready = rst_n && !full;
  assign push          = bus.cmd_valid && bus.cmd_ready;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (alu_cmd_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_cmd),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

`ifdef ALU_SEQ_CHAIN_EN
  logic [DATA_W-1:0] last_w;

  // The previous command is always captured before the next one pops, so
  // last_w is exactly the result of the preceding command in order.
  assign a_sel = head.chain ? last_w : head.a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_w <= '0;
    end else if (capture) begin
      last_w <= bus.alu_w;
    end
  end
`else
  logic unused_chain;

  assign unused_chain = bus.cmd_chain;
  assign a_sel        = head.a;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    cnt_dec     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end else begin
          cnt_dec   = 1'b1;
        end
      end
      HOLD: begin
        // Releasing the result and issuing the next command share one edge,
        // which is what gives one result per SETTLE+1 cycles.
        if (bus.res_ready) begin
          release_res = 1'b1;
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = DRIVE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: issue popped command onto the ALU inputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_p0   <= '0;
      alu_b_p0   <= '0;
      alu_cin_p0 <= 1'b0;
      alu_opc_p0 <= '0;
      cnt        <= '0;
    end else if (pop) begin
      alu_a_p0   <= a_sel;
      alu_b_p0   <= head.b;
      alu_cin_p0 <= head.cin;
      alu_opc_p0 <= head.opc;
      cnt        <= CNT_W'(SETTLE - 1);
    end else if (cnt_dec) begin
      cnt        <= cnt - 1'b1;
    end
  end

  // ---- stage p1: capture settled ALU result toward the consumer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_w_p1    <= '0;
      res_zero_p1 <= 1'b0;
      res_neg_p1  <= 1'b0;
      vld_p1      <= 1'b0;
    end else if (capture) begin
      res_w_p1    <= bus.alu_w;
      res_zero_p1 <= bus.alu_zero;
      res_neg_p1  <= bus.alu_neg;
      vld_p1      <= 1'b1;
    end else if (release_res) begin
      vld_p1      <= 1'b0;
    end
  end

  assign bus.alu_a     = alu_a_p0;
  assign bus.alu_b     = alu_b_p0;
  assign bus.alu_cin   = alu_cin_p0;
  assign bus.alu_opc   = alu_opc_p0;
  assign bus.res_w     = res_w_p1;
  assign bus.res_zero  = res_zero_p1;
  assign bus.res_neg   = res_neg_p1;
  assign bus.res_valid = vld_p1;
  assign bus.busy      = !empty || (state != IDLE);

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Upstream operand/command stage for the 16-bit combinational ALU. It buffers ALU commands in a small FIFO, issues them one at a time on registered ALU input ports, and waits a configurable settle time. It then captures the ALU result and zero/negative flags into a result register with a valid/ready handshake toward the downstream consumer.

## Interface
- DEPTH, 4, command FIFO entries (power of 2, ≥2)
- SETTLE, 1, cycles the ALU inputs are held before capture (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_a, cmd_b  in  16 each  operands
- cmd_cin  in  1  carry-in
- cmd_opc  in  3  ALU opcode, passed through unmodified
- cmd_chain  in  1  substitute previous result for operand A (see Configuration)
- alu_a, alu_b  out  16 each  registered ALU operand drive
- alu_cin  out  1  registered ALU carry-in
- alu_opc  out  3  registered ALU opcode
- alu_w  in  16  ALU result
- alu_zero, alu_neg  in  1 each  ALU flags
- res_valid / res_ready  out / in  1 / 1  result handshake
- res_w  out  16  captured result
- res_zero, res_neg  out  1 each  captured flags
- busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- FIFO: push on cmd_valid&&cmd_ready; cmd_ready = !full, forced 0 while rst_n is low. Push and pop on the same edge are legal; count is then unchanged. There is no bypass: a command pushed into an empty FIFO is popped on the next edge at the earliest.
- FSM states IDLE, DRIVE, HOLD:
  - IDLE: on an edge with FIFO non-empty, pop the head, load the alu_* registers, set cnt=SETTLE-1, go to DRIVE.
  - DRIVE: while cnt≠0, decrement. On the edge with cnt==0, capture alu_w/alu_zero/alu_neg into res_*, set res_valid=1, update last_w=alu_w, go to HOLD.
  - HOLD: res_* stable while res_valid && !res_ready. On the handshake edge: if FIFO non-empty, pop the next command in that same edge (to DRIVE) and clear res_valid; otherwise clear res_valid and go to IDLE.
- alu_* registers hold the last issued command until the next pop; they are not cleared between commands.
- Results are delivered in command order. No command is dropped or duplicated.
- Reset mid-operation: asynchronous clear of FIFO pointers, count, FSM (to IDLE), cnt, last_w and all outputs. Queued and in-flight commands are discarded.
- Reset values: alu_a=0, alu_b=0, alu_cin=0, alu_opc=0, res_valid=0, res_w=0, res_zero=0, res_neg=0, busy=0, cmd_ready=0 during reset and 1 after release.

## Timing
- Command accepted on edge k into an idle, empty block: alu_* are valid after edge k+1, res_valid rises after edge k+1+SETTLE.
- Latency with SETTLE=1 is 2 cycles.
- Sustained throughput with res_ready=1 is one result per SETTLE+1 cycles.
- With res_ready=0, the FIFO fills to DEPTH behind one held result: DEPTH+1 commands are accepted before cmd_ready drops.

## Configuration
- ALU_SEQ_CHAIN_EN defined:
  - A popped command with cmd_chain=1 loads alu_a from last_w (the most recent captured result, 0 after reset) instead of cmd_a.
  - The FIFO stores the chain bit.
- ALU_SEQ_CHAIN_EN undefined:
  - cmd_chain is ignored and not stored.
  - alu_a always equals cmd_a.
  - last_w is not implemented.

## Structure
- Package alu_pkg holds:
  - DATA_W=16 and OPC_W=3
  - typedef alu_cmd_t: struct of a, b, cin, opc and, under the macro, chain
  - typedef seq_state_t: enum IDLE, DRIVE, HOLD
- Sub-module alu_cmd_fifo: parameterised by DEPTH and element type alu_cmd_t, with push/pop/full/empty and async active-low reset.
- The FSM, settle counter and result register live in alu_cmd_sequencer.

## Test plan
All scenarios use an ALU stub that returns alu_w=alu_a^alu_b, alu_zero=(alu_w==0), alu_neg=alu_w[15].
- Reset: after rst_n released, alu_a=0, res_valid=0, busy=0 and cmd_ready=1; with cmd_valid=0, outputs stay unchanged for 10 cycles.
- Single command, SETTLE=1: a=0x1234, b=0x00FF, opc=3, cin=1, accepted on edge k.
  - After edge k+1: alu_a=0x1234, alu_opc=3, alu_cin=1.
  - After edge k+2: res_valid=1, res_w=0x12CB, zero=0, neg=0.
- Flags:
  - a=b=0x8001 gives res_w=0x0000 with res_zero=1.
  - a=0xFF00, b=0x0000 gives res_neg=1 and res_zero=0.
- Backpressure, DEPTH=4, res_ready=0: offer 6 commands. 5 are accepted, cmd_ready=0 while the 6th waits, and res_w stays stable. Then hold res_ready=1: all 6 results arrive in order, one every 2 cycles.
- Chaining: cmd1 a=0x00F0, b=0x000F gives 0x00FF. Then cmd2 chain=1, a=0xDEAD, b=0x0F0F:
  - Macro defined: alu_a=0x00FF, res_w=0x0FF0.
  - Macro undefined: alu_a=0xDEAD, res_w=0xD1A2.
- Reset mid-operation: with 3 commands queued and FSM in DRIVE, pulse rst_n low for 1 cycle. res_valid=0 and busy=0 immediately, and no result appears in the following 10 cycles.
